// File: rtl/llc_cache_ctrl_pkg.sv
// Shared types and width helpers for the LLC tag controller.
// Command and FSM state encodings plus address-split width derivation.
package cache_define;

   typedef enum logic [2:0] {
      READ       = 3'd0,
      WRITE      = 3'd1,
      INVALIDATE = 3'd2,
      CLEAR      = 3'd3
   } cache_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      SWEEP
   } ctrl_state_t;

   function automatic int off_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int sets, input int line_bytes);
      return addr_w - idx_w(sets) - off_w(line_bytes);
   endfunction

endpackage

// File: rtl/llc_cache_ctrl_if.sv
// Command/response bus between the trace-driven command source and the LLC tag controller.
interface llc_cache_ctrl_if import cache_define::*; #(
   parameter int ADDR_W     = 32,
   parameter int SETS       = 4,
   parameter int WAYS       = 4,
   parameter int LINE_BYTES = 64,
   parameter int CNT_W      = 32
);
   localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_BYTES);
   localparam int WAY_W = $clog2(WAYS);

   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_cmd;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_hit;
   logic [WAY_W-1:0]  rsp_way;
   logic              rsp_evict;
   logic [TAG_W-1:0]  rsp_evict_tag;
   logic              rsp_evict_dirty;
   logic              rsp_err;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   modport master (
      output req_valid, req_cmd, req_addr,
      input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag,
             rsp_evict_dirty, rsp_err, hit_count, miss_count
   );

   modport slave (
      input  req_valid, req_cmd, req_addr,
      output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag,
             rsp_evict_dirty, rsp_err, hit_count, miss_count
   );

endinterface

// File: rtl/llc_cache_ctrl_plru_tree.sv
// Tree-PLRU for one set: victim pick (lowest invalid way, else follow the tree)
// and the updated tree bits after touching acc_way. Purely combinational.
module plru_tree #(
   parameter  int WAYS  = 4,
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-2:0]  plru,
   input  logic [WAYS-1:0]  valid,
   input  logic [WAY_W-1:0] acc_way,
   output logic [WAY_W-1:0] victim,
   output logic [WAYS-2:0]  plru_nxt
);

   always_comb begin : victim_sel
      logic found;
      logic b;
      int   node;
      victim = '0;
      found  = 1'b0;
      node   = 0;
      b      = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w]) begin
            victim = WAY_W'(w);
            found  = 1'b1;
         end
      end
      // Walk root to leaf; each bit picked is the next MSB of the victim way.
      if (!found) begin
         for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int n = 0; n < WAYS - 1; n++)
               if (n == node) b = plru[n];
            victim[WAY_W-1-l] = b;
            node = 2 * node + 1 + int'(b);
         end
      end
   end

   always_comb begin : plru_upd
      int node;
      plru_nxt = plru;
      node     = 0;
      for (int l = 0; l < WAY_W; l++) begin
         node = (1 << l) - 1 + int'(acc_way >> (WAY_W - l));
         for (int n = 0; n < WAYS - 1; n++)
            if (n == node) plru_nxt[n] = ~acc_way[WAY_W-1-l];
      end
   end

endmodule

// File: rtl/llc_cache_ctrl.sv
// Set-associative LLC tag controller: one command per handshake, response one
// cycle after acceptance, tree-PLRU replacement, saturating hit/miss stats.
module llc_cache_ctrl import cache_define::*; #(
   parameter int ADDR_W     = 32,
   parameter int SETS       = 4,
   parameter int WAYS       = 4,
   parameter int LINE_BYTES = 64,
   parameter int CNT_W      = 32
) (
   input logic            clk,
   input logic            rst,
   llc_cache_ctrl_if.slave bus
);
   localparam int OFF_W = off_w(LINE_BYTES);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_BYTES);
   localparam int WAY_W = $clog2(WAYS);

   ctrl_state_t state_q, state_d;
   logic              req_ready, accept;
   logic [2:0]        cmd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [IDX_W-1:0]  set_cnt;

   logic [SETS-1:0][WAYS-1:0]            valid_q, dirty_q;
   logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_q;
   logic [SETS-1:0][WAYS-2:0]            plru_q;

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic [WAY_W-1:0] hit_way, victim, acc_way;
   logic [WAYS-2:0]  plru_upd;
   logic             unused_off;

   assign lk_idx     = addr_q[OFF_W +: IDX_W];
   assign lk_tag     = addr_q[ADDR_W-1 -: TAG_W];
   assign unused_off = ^addr_q[OFF_W-1:0];

   always_comb begin
      lk_hit  = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
            lk_hit  = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   assign acc_way = lk_hit ? hit_way : victim;

   plru_tree #(.WAYS(WAYS)) u_plru (
      .plru     (plru_q[lk_idx]),
      .valid    (valid_q[lk_idx]),
      .acc_way  (acc_way),
      .victim   (victim),
      .plru_nxt (plru_upd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (bus.req_cmd == CLEAR) ? SWEEP : LOOKUP;
         LOOKUP:  state_d = IDLE;
         SWEEP:   if (set_cnt == IDX_W'(SETS - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      accept    = req_ready && bus.req_valid;
   end

   assign bus.req_ready = req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_q               <= '0;
         addr_q              <= '0;
         set_cnt             <= '0;
         valid_q             <= '0;
         dirty_q             <= '0;
         tag_q               <= '0;
         plru_q              <= '0;
         bus.rsp_valid       <= 1'b0;
         bus.rsp_hit         <= 1'b0;
         bus.rsp_way         <= '0;
         bus.rsp_evict       <= 1'b0;
         bus.rsp_evict_tag   <= '0;
         bus.rsp_evict_dirty <= 1'b0;
         bus.rsp_err         <= 1'b0;
         bus.hit_count       <= '0;
         bus.miss_count      <= '0;
      end else begin
         // Response fields are only meaningful in the rsp_valid cycle.
         bus.rsp_valid       <= 1'b0;
         bus.rsp_hit         <= 1'b0;
         bus.rsp_way         <= '0;
         bus.rsp_evict       <= 1'b0;
         bus.rsp_evict_tag   <= '0;
         bus.rsp_evict_dirty <= 1'b0;
         bus.rsp_err         <= 1'b0;
         if (accept) begin
            cmd_q   <= bus.req_cmd;
            addr_q  <= bus.req_addr;
            set_cnt <= '0;
         end
         case (state_q)
            LOOKUP: begin
               bus.rsp_valid <= 1'b1;
               case (cmd_q)
                  READ, WRITE: begin
                     bus.rsp_hit    <= lk_hit;
                     bus.rsp_way    <= acc_way;
                     plru_q[lk_idx] <= plru_upd;
                     if (lk_hit) begin
                        if (cmd_q == WRITE) dirty_q[lk_idx][hit_way] <= 1'b1;
                        if (~&bus.hit_count) bus.hit_count <= bus.hit_count + CNT_W'(1);
                     end else begin
                        if (valid_q[lk_idx][victim]) begin
                           bus.rsp_evict       <= 1'b1;
                           bus.rsp_evict_tag   <= tag_q[lk_idx][victim];
                           bus.rsp_evict_dirty <= dirty_q[lk_idx][victim];
                        end
                        valid_q[lk_idx][victim] <= 1'b1;
                        dirty_q[lk_idx][victim] <= (cmd_q == WRITE);
                        tag_q[lk_idx][victim]   <= lk_tag;
                        if (~&bus.miss_count) bus.miss_count <= bus.miss_count + CNT_W'(1);
                     end
                  end
                  INVALIDATE: begin
                     bus.rsp_hit <= lk_hit;
                     if (lk_hit) begin
                        bus.rsp_way              <= hit_way;
                        bus.rsp_evict            <= 1'b1;
                        bus.rsp_evict_tag        <= tag_q[lk_idx][hit_way];
                        bus.rsp_evict_dirty      <= dirty_q[lk_idx][hit_way];
                        valid_q[lk_idx][hit_way] <= 1'b0;
                        dirty_q[lk_idx][hit_way] <= 1'b0;
                     end
                  end
                  default: bus.rsp_err <= 1'b1;
               endcase
            end
            SWEEP: begin
               valid_q[set_cnt] <= '0;
               dirty_q[set_cnt] <= '0;
               plru_q[set_cnt]  <= '0;
               set_cnt          <= set_cnt + IDX_W'(1);
               if (set_cnt == IDX_W'(SETS - 1)) bus.rsp_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/llc_cache_ctrl.md
# llc_cache_ctrl

Parametrised, clocked set-associative last-level-cache tag controller: the next generation of the LLC simulator cache model. It accepts one command per handshake (read, write, invalidate, clear) and keeps per-set tag, valid, dirty and tree-PLRU state. It returns hit/miss, way and eviction information one cycle after acceptance, and maintains hit/miss statistics. It sits between the trace-driven command source and the bus/snoop reporting logic.

## Interface
- ADDR_W, 32, address width
- SETS, 4, number of sets; power of two, ≥2
- WAYS, 4, associativity; power of two, ≥2
- LINE_BYTES, 64, line size in bytes; power of two
- CNT_W, 32, statistics counter width
- Derived widths:
  - OFF_W = clog2(LINE_BYTES)
  - IDX_W = clog2(SETS)
  - TAG_W = ADDR_W − IDX_W − OFF_W (24 at defaults)
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- req_valid  in  1  command present
- req_ready  out  1  controller can accept
- req_cmd  in  3  cache_cmd_t: READ=0, WRITE=1, INVALIDATE=2, CLEAR=3; others illegal
- req_addr  in  ADDR_W  byte address
- rsp_valid  out  1  one-cycle response pulse
- rsp_hit  out  1  tag matched a valid way
- rsp_way  out  clog2(WAYS)  hit, allocated or invalidated way
- rsp_evict  out  1  a valid line was displaced or invalidated
- rsp_evict_tag  out  TAG_W  tag of that line
- rsp_evict_dirty  out  1  that line was dirty (writeback needed)
- rsp_err  out  1  illegal command
- hit_count  out  CNT_W  READ/WRITE hits, saturating
- miss_count  out  CNT_W  READ/WRITE misses, saturating

## Operation
- Address split:
  - offset = addr[OFF_W-1:0], ignored
  - index = next IDX_W bits
  - tag = upper TAG_W bits
- Per set: WAYS × {valid, dirty, tag} and WAYS−1 PLRU bits.
- PLRU tree:
  - Node 0 is the root; node n has children 2n+1 and 2n+2.
  - Bit 0 means the victim is in the left subtree; bit 1 means right.
  - On an access to way w, every node on w's path is set to point away from w.
- Victim selection: the lowest-index invalid way; if all ways are valid, follow the PLRU bits.
- READ:
  - Hit: touch PLRU, hit_count+1.
  - Miss: allocate victim (tag, valid=1, dirty=0), touch PLRU, miss_count+1, report eviction if the victim was valid.
- WRITE: as READ, but the hit or allocated line gets dirty=1 (write-allocate).
- INVALIDATE:
  - Hit: clear valid and dirty; rsp_evict=1 with the old tag/dirty.
  - Miss: no change.
  - PLRU and counters are untouched in both cases.
- CLEAR: sweep one set per cycle from 0 to SETS−1, clearing valid, dirty and PLRU. Counters are kept.
- Illegal cmd: rsp_err=1, rsp_hit=0, no state change.
- FSM states:
  - IDLE: req_ready=1.
  - IDLE → LOOKUP on accept of READ/WRITE/INVALIDATE/illegal.
  - IDLE → SWEEP on accept of CLEAR.
  - LOOKUP → IDLE after one cycle.
  - SWEEP → IDLE after the set counter reaches SETS−1.
- Counters saturate at all-ones; they are never cleared except by rst.

## Timing
- Accept when req_valid && req_ready at edge N; cmd and addr are registered.
- LOOKUP cycle: compare and victim select, combinationally.
- Edge N+1: arrays and counters updated; rsp_* registered; rsp_valid high for the cycle after N+1.
- Latency is one cycle after acceptance; throughput is one command per 2 cycles.
- req_ready is high again in the same cycle as rsp_valid; a request accepted then is back-to-back legal.
- CLEAR takes SETS cycles in SWEEP, then rsp_valid for one cycle with rsp_hit=0 and rsp_evict=0.
- No response backpressure: rsp_* hold only during the rsp_valid cycle.
- Reset values: every output 0 except req_ready=1. All valid/dirty/PLRU bits are 0 and the state is IDLE.
- rst mid-LOOKUP or mid-SWEEP: immediate return to IDLE, no response issued, all state cleared.
- A command arriving while req_ready=0 is not accepted; the requester holds it.

## Structure
- Shared package cache_define holds:
  - cache_cmd_t
  - ctrl_state_t (IDLE, LOOKUP, SWEEP)
  - helper functions for TAG_W/IDX_W derivation
- Sub-module plru_tree, parametrised by WAYS:
  - inputs: plru bits, valid vector, access way
  - outputs: victim way, updated plru bits
  - purely combinational, one instance

## Test plan
- Reset, then READ 0x00000040: rsp_hit=0, rsp_way=0, rsp_evict=0, miss_count=1; repeat → rsp_hit=1, rsp_way=0, hit_count=1.
- Set 0 PLRU eviction:
  - READ tags A, B, C, D (ways 0–3), then READ A.
  - READ new tag E → rsp_way=2, rsp_evict=1, rsp_evict_tag=C, rsp_evict_dirty=0.
- WRITE 0x12345600 (miss, dirty), then INVALIDATE 0x12345600 → rsp_hit=1, rsp_evict=1, rsp_evict_dirty=1; a following READ misses.
- Fill sets 0–3, issue CLEAR:
  - req_ready low for 4 cycles, then one rsp_valid.
  - Subsequent READs all miss; hit/miss counts are kept.
- req_cmd=5 → rsp_err=1 next cycle, counters and arrays unchanged; assert rst during a LOOKUP → no rsp_valid, outputs at reset values.
- Back-to-back: req_valid held high for 10 READs → accepted every 2 cycles, one rsp_valid per request, none lost.
